// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller for an external dual-port SRAM with a FWFT output register
//
// Purpose: turns an upstream valid/ready stream into SRAM writes and prefetches
// the head entry into a one-deep output register, giving a first-word-fall-through
// valid/ready stream downstream. Capacity is DEPTH (SRAM) + 1 (output register).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous clear of all state (SRAM contents untouched)
//   in_valid/in_ready/in_data     upstream stream
//   out_valid/out_ready/out_data  downstream stream, out_data registered
//   level             entries held (SRAM count + output register)
//   almost_full       level >= AFULL_TH (registered)
//   almost_empty      level <= AEMPTY_TH (registered)
//   ram_wr_en/addr/data  SRAM write port
//   ram_rd_en/addr       SRAM read port request
//   ram_rd_data          SRAM read data, combinational from ram_rd_addr

module dpram_fifo_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int DEPTH     = 1 << AW,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data
);

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_L  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AEMPTY_L = (AW+1)'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;

  logic          push;
  logic          pop;
  logic          refill;
  logic [AW:0]   cnt_nxt;
  logic          ov_nxt;
  logic [AW:0]   level_nxt;

  // Full is judged on the SRAM count alone; a same-cycle refill only frees a
  // slot for the following cycle, which keeps in_ready independent of out_ready.
  assign in_ready = (ram_cnt != DEPTH_L);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign refill   = (ram_cnt != '0) & (~out_valid | pop);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = refill;
  assign ram_rd_addr = rd_ptr;

  always_comb begin
    cnt_nxt = ram_cnt + (AW+1)'(push) - (AW+1)'(refill);
    ov_nxt  = out_valid;
    if (refill) begin
      ov_nxt = 1'b1;
    end else if (pop) begin
      ov_nxt = 1'b0;
    end
    level_nxt = cnt_nxt + (AW+1)'(ov_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      // Pointers wrap explicitly so DEPTH need not be a power of two.
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (refill) begin
        rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
        out_data <= ram_rd_data;
      end
      ram_cnt      <= cnt_nxt;
      out_valid    <= ov_nxt;
      level        <= level_nxt;
      almost_full  <= (level_nxt >= AFULL_L);
      almost_empty <= (level_nxt <= AEMPTY_L);
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - directed self-checking bench for dpram_fifo_ctrl

module tb_dpram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic          almost_full;
  logic          almost_empty;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem [DEPTH];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd_data = mem[ram_rd_addr];

  dpram_fifo_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .AFULL_TH(3), .AEMPTY_TH(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lvl_exp [6] = '{1, 2, 3, 4, 5, 5};
  int af_exp  [6] = '{0, 0, 1, 1, 1, 1};
  int exp_out;
  int next_in;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_out_data", 32'(out_data), 0);

    // T2 latency
    in_valid = 1'b1; in_data = 8'hA5; #1;
    check("t2_wr_en", 32'(ram_wr_en), 1);
    check("t2_wr_addr", 32'(ram_wr_addr), 0);
    tick();
    in_valid = 1'b0; #1;
    check("t2_lvl_t1", 32'(level), 1);
    check("t2_ov_t1", 32'(out_valid), 0);
    check("t2_rd_en_t1", 32'(ram_rd_en), 1);
    tick();
    check("t2_ov_t2", 32'(out_valid), 1);
    check("t2_data_t2", 32'(out_data), 32'hA5);
    check("t2_lvl_t2", 32'(level), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    check("t2_drain_ov", 32'(out_valid), 0);
    check("t2_drain_lvl", 32'(level), 0);

    // T3 fill; write pointer starts at 1 after the A5 push
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); #1;
      if (i < 5) begin
        check($sformatf("t3_in_ready_%0d", i), 32'(in_ready), 1);
        check($sformatf("t3_wr_addr_%0d", i), 32'(ram_wr_addr), 32'((i + 1) % 4));
      end else begin
        check("t3_full_in_ready", 32'(in_ready), 0);
        check("t3_full_wr_en", 32'(ram_wr_en), 0);
      end
      tick();
      check($sformatf("t3_level_%0d", i), 32'(level), 32'(lvl_exp[i]));
      check($sformatf("t3_afull_%0d", i), 32'(almost_full), 32'(af_exp[i]));
    end
    check("t3_head", 32'(out_data), 1);

    // T4 drain with wrap; value 6 is still held on the input
    exp_out = 1; next_in = 6; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (next_in <= 10) begin
        in_valid = 1'b1; in_data = 8'(next_in);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check($sformatf("t4_data_%0d", exp_out), 32'(out_data), 32'(exp_out));
        exp_out++;
      end
      if (in_valid && in_ready) next_in++;
      tick();
      if (exp_out == 11 && level == 0) break;
    end
    check("t4_count", 32'(exp_out), 11);
    check("t4_level", 32'(level), 0);
    check("t4_ov", 32'(out_valid), 0);
    check("t4_aempty", 32'(almost_empty), 1);

    // T5 concurrent push/pop on a 2-deep backlog
    in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h20;
    tick();
    in_data = 8'h21;
    tick();
    check("t5_backlog_lvl", 32'(level), 2);
    check("t5_backlog_aempty", 32'(almost_empty), 0);
    check("t5_backlog_head", 32'(out_data), 32'h20);
    for (int j = 0; j < 20; j++) begin
      in_valid = 1'b1; in_data = 8'(8'h22 + j); out_ready = 1'b1; #1;
      check($sformatf("t5_in_ready_%0d", j), 32'(in_ready), 1);
      check($sformatf("t5_data_%0d", j), 32'(out_data), 32'(8'h20 + j));
      tick();
      check($sformatf("t5_level_%0d", j), 32'(level), 2);
    end
    in_valid = 1'b0;
    exp_out = 8'h34;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        check($sformatf("t5_tail_%0d", exp_out), 32'(out_data), 32'(exp_out));
        exp_out++;
      end
      tick();
    end
    check("t5_tail_count", 32'(exp_out), 32'h36);
    check("t5_empty", 32'(level), 0);

    // T6 flush at level 4 together with a push
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + k);
      tick();
    end
    check("t6_pre_level", 32'(level), 4);
    check("t6_pre_afull", 32'(almost_full), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("t6_level", 32'(level), 0);
    check("t6_ov", 32'(out_valid), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_afull", 32'(almost_full), 0);
    check("t6_aempty", 32'(almost_empty), 1);
    in_valid = 1'b1; in_data = 8'h3C; #1;
    check("t6_wr_addr", 32'(ram_wr_addr), 0);
    tick();
    in_valid = 1'b0; #1;
    check("t6_ov_t1", 32'(out_valid), 0);
    tick();
    check("t6_ov_t2", 32'(out_valid), 1);
    check("t6_data_t2", 32'(out_data), 32'h3C);

    // T1 reset mid-traffic
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    check("t1_ov", 32'(out_valid), 0);
    check("t1_level", 32'(level), 0);
    check("t1_in_ready", 32'(in_ready), 1);
    check("t1_aempty", 32'(almost_empty), 1);
    check("t1_wr_en", 32'(ram_wr_en), 0);
    check("t1_out_data", 32'(out_data), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
